// File: rtl/riscv_core_pkg.sv
// Shared encodings for the 8-bit multicycle core.
// Build option: RISCV_CORE_MUL_EN enables the SPC multiply.
package riscv_core_pkg;

    localparam int XLEN = 8;

    localparam logic [1:0] OP_ADDI = 2'b00;
    localparam logic [1:0] OP_LI   = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_SPC  = 2'b11;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_SUB = 2'b01;
    localparam logic [1:0] F_AND = 2'b10;
    localparam logic [1:0] F_XOR = 2'b11;

    localparam logic [1:0] F_NOP = 2'b00;
    localparam logic [1:0] F_SHL = 2'b01;
    localparam logic [1:0] F_SHR = 2'b10;
    localparam logic [1:0] F_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } state_e;

    localparam int UIO_BUSY   = 7;
    localparam int UIO_DONE   = 6;
    localparam int UIO_RD_HI  = 5;
    localparam int UIO_RD_LO  = 4;
    localparam int UIO_CNT_HI = 3;
    localparam int UIO_CNT_LO = 1;

endpackage

// File: rtl/riscv_core_alu.sv
// Combinational execute unit: result and write-enable per opcode.
// Build option: RISCV_CORE_MUL_EN adds the 8x8 low-half multiply.
module riscv_core_alu
    import riscv_core_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    input  logic [1:0]   f_i,
    output logic [W-1:0] res_o,
    output logic         we_o
);

`ifdef RISCV_CORE_MUL_EN
    logic [W-1:0] prod;
    assign prod = a_i * b_i;
`endif

    always_comb begin
        res_o = a_i;
        we_o  = 1'b1;
        unique case (op_i)
            OP_ADDI: res_o = a_i + b_i;
            OP_LI:   res_o = b_i;
            OP_ALU: begin
                unique case (f_i)
                    F_ADD: res_o = a_i + b_i;
                    F_SUB: res_o = a_i - b_i;
                    F_AND: res_o = a_i & b_i;
                    F_XOR: res_o = a_i ^ b_i;
                endcase
            end
            OP_SPC: begin
                unique case (f_i)
                    F_NOP: we_o  = 1'b0;
                    F_SHL: res_o = a_i << 1;
                    F_SHR: res_o = a_i >> 1;
`ifdef RISCV_CORE_MUL_EN
                    F_MUL: res_o = prod;
`else
                    F_MUL: we_o  = 1'b0;
`endif
                endcase
            end
        endcase
    end

endmodule

// File: rtl/riscv_core_top.sv
// Strobe-driven 8-bit multicycle core: IDLE->DECODE->EXEC->WB.
// Build option: RISCV_CORE_MUL_EN enables SPC multiply.
module riscv_core_top
    import riscv_core_pkg::*;
#(
    parameter int DATA_W      = XLEN,
    parameter int EDGE_DETECT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e state_q, state_d;

    logic [7:0]        ir_q;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] res_q;
    logic              we_q;
    logic [DATA_W-1:0] uo_q;
    logic              done_q;
    logic [1:0]        rd_last_q;
    logic [2:0]        cnt_q;
    logic              strb_q;

    logic              accept;
    logic              strb;
    logic [1:0]        op, rd, rs, fn;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;
    logic              alu_we;
    logic              unused_ok;

    assign unused_ok = ^uio_in[7:1];

    assign strb   = uio_in[0];
    assign accept = ena && (state_q == ST_IDLE) && strb
                 && ((EDGE_DETECT == 0) || !strb_q);

    assign op = ir_q[7:6];
    assign rd = ir_q[5:4];
    assign rs = ir_q[1:0];
    assign fn = ir_q[3:2];

    // ADDI/LI take the zero-extended immediate; ALU/SPC read rs.
    always_comb begin
        opb = rf_q[rs];
        if (op == OP_ADDI || op == OP_LI) begin
            opb = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        end
    end

    riscv_core_alu #(.W(DATA_W)) u_alu (
        .a_i   (rf_q[rd]),
        .b_i   (opb),
        .op_i  (op),
        .f_i   (fn),
        .res_o (alu_res),
        .we_o  (alu_we)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            res_q     <= '0;
            we_q      <= 1'b0;
            uo_q      <= '0;
            done_q    <= 1'b0;
            rd_last_q <= '0;
            cnt_q     <= '0;
            strb_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            strb_q  <= strb;
            done_q  <= (state_q == ST_WB);
            if (accept) begin
                ir_q <= ui_in;
            end
            if (state_q == ST_EXEC) begin
                res_q <= alu_res;
                we_q  <= alu_we;
            end
            // NOP still reports rd's current value and counts.
            if (state_q == ST_WB) begin
                if (we_q) begin
                    rf_q[rd] <= res_q;
                end
                uo_q      <= we_q ? res_q : rf_q[rd];
                rd_last_q <= rd;
                cnt_q     <= cnt_q + 3'd1;
            end
        end
    end

    assign uo_out = uo_q[7:0];
    assign uio_oe = 8'hFE;

    always_comb begin
        uio_out = '0;
        uio_out[UIO_BUSY] = (state_q != ST_IDLE);
        uio_out[UIO_DONE] = done_q;
        uio_out[UIO_RD_HI:UIO_RD_LO]   = rd_last_q;
        uio_out[UIO_CNT_HI:UIO_CNT_LO] = cnt_q;
    end

endmodule

// File: tb/tb_riscv_core_top.sv
// Directed plus random bench for riscv_core_top against a reference model.
module tb_riscv_core_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RISCV_CORE_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    int m_rf [4];
    int m_uo;
    int m_rd;
    int m_cnt;

    always #5 clk = ~clk;

    riscv_core_top dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_uo  = 0;
        m_rd  = 0;
        m_cnt = 0;
    endfunction

    function automatic void m_exec(input logic [7:0] ins);
        int rd, imm, a, b, r, f;
        bit wr;
        rd  = int'(ins[5:4]);
        imm = int'(ins[3:0]);
        f   = imm / 4;
        a   = m_rf[rd];
        b   = m_rf[imm % 4];
        r   = a;
        wr  = 1'b1;
        case (int'(ins[7:6]))
            0: r = (a + imm) % 256;
            1: r = imm;
            2: case (f)
                   0: r = (a + b) % 256;
                   1: r = (a - b + 256) % 256;
                   2: r = a & b;
                   default: r = a ^ b;
               endcase
            default: case (f)
                   0: wr = 1'b0;
                   1: r = (a * 2) % 256;
                   2: r = a / 2;
                   default: if (MUL) r = (a * b) % 256; else wr = 1'b0;
               endcase
        endcase
        if (wr) m_rf[rd] = r;
        m_uo  = m_rf[rd];
        m_rd  = rd;
        m_cnt = (m_cnt + 1) % 8;
    endfunction

    function automatic logic [7:0] m_status(input bit busy, input bit done);
        logic [1:0] rdv;
        logic [2:0] cv;
        rdv = 2'(m_rd);
        cv  = 3'(m_cnt);
        return {busy, done, rdv, cv, 1'b0};
    endfunction

    task automatic run(input logic [7:0] ins);
        logic [7:0] old;
        old    = 8'(m_uo);
        ui_in  = ins;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        chk("busy_after_accept", {7'd0, uio_out[7]}, 8'h01);
        tick();
        tick();
        chk("uo_before_wb", uo_out, old);
        chk("done_before_wb", {7'd0, uio_out[6]}, 8'h00);
        m_exec(ins);
        tick();
        chk("uo_after_wb", uo_out, 8'(m_uo));
        chk("status_done", uio_out, m_status(1'b0, 1'b1));
        tick();
        chk("status_idle", uio_out, m_status(1'b0, 1'b0));
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_reset();
        repeat (10) tick();
        rst = 1'b0;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFE);

        ui_in  = 8'h55;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        repeat (5) tick();
        chk("ena0_uio", uio_out, 8'h00);
        chk("ena0_uo", uo_out, 8'h00);
        ena = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run(8'(i));
            repeat (10) tick();
        end
        chk("addi_sum", uo_out, 8'h42);
        chk("addi_cnt", {5'd0, uio_out[3:1]}, 8'h04);
        chk("addi_rd", {6'd0, uio_out[5:4]}, 8'h00);

        run(8'h55);
        run(8'h63);
        run(8'h96);
        chk("alu_sub", uo_out, 8'h02);

        ui_in  = 8'h01;
        uio_in = 8'h01;
        repeat (5) tick();
        uio_in = 8'h00;
        repeat (5) tick();
        m_exec(8'h01);
        chk("held_uo", uo_out, 8'(m_uo));
        chk("held_status", uio_out, m_status(1'b0, 1'b0));

        ui_in  = 8'h01;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        tick();
        ui_in  = 8'h02;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        repeat (6) tick();
        m_exec(8'h01);
        chk("busy_drop_uo", uo_out, 8'(m_uo));
        chk("busy_drop_status", uio_out, m_status(1'b0, 1'b0));

        run(8'h7F);
        run(8'hF4);
        chk("shl", uo_out, 8'h1E);
        run(8'hF8);
        chk("shr", uo_out, 8'h0F);
        run(8'hFF);
        chk("mul", uo_out, MUL ? 8'hE1 : 8'h0F);

        repeat (60) begin
            run(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        ui_in  = 8'h0F;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        m_reset();
        chk("abort_uo", uo_out, 8'h00);
        chk("abort_uio", uio_out, 8'h00);
        repeat (3) tick();
        chk("abort_idle", uio_out, 8'h00);
        run(8'h00);
        chk("abort_r0", uo_out, 8'h00);
        run(8'h21);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
